coeff_loader: RTL and testbench

- Byte-stream-to-word loader that drives the write port of the 8-bank coefficient memory (addressW, datain, we).
- Sits between the serial receiver (byte + one-cycle ready strobe) and the memory bank.
- Parses framed burst writes: sync byte, 9-bit start address, word count, then 5 bytes per 36-bit coefficient pair.
- Auto-increments the address and aborts stalled frames by timeout.

---
 rtl/coeff_loader_pkg.sv | 22 ++
 rtl/coeff_loader_if.sv | 30 +++
 rtl/coeff_loader_rx_timeout.sv | 34 +++
 rtl/coeff_loader.sv | 129 ++++++++++++
 tb/tb_coeff_loader.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/coeff_loader_pkg.sv
// Shared types and constants for the coefficient loader slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package coeff_loader_pkg;

  localparam int ADDR_W         = 9;
  localparam int WORD_W         = 36;
  localparam int BYTES_PER_WORD = 5;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Parser states, kept as plain constants so older tools and dumps decode them.
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDR_H = 3'd1;
  localparam logic [2:0] ADDR_L = 3'd2;
  localparam logic [2:0] COUNT  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/coeff_loader_if.sv
// Byte input plus memory write port of the coefficient loader.
// Latency: n/a (wiring only).
// Backpressure: none; rxready is a strobe and the memory port is always ready.
// Signals: rxdata/rxready (byte in), addressW/datain/we (memory write),
//          busy/done/error (frame status).
interface coeff_loader_if;
  import coeff_loader_pkg::*;

  logic [7:0] rxdata;
  logic       rxready;
  addr_t      addressW;
  word_t      datain;
  logic       we;
  logic       busy;
  logic       done;
  logic       error;

  // master: the side that feeds bytes and watches the memory port.
  modport master (
    output rxdata, rxready,
    input  addressW, datain, we, busy, done, error
  );

  // slave: the loader itself.
  modport slave (
    input  rxdata, rxready,
    output addressW, datain, we, busy, done, error
  );

endinterface

// File: rtl/coeff_loader_rx_timeout.sv
// Idle-gap watchdog: counts clocks while enabled and no byte arrives.
// Latency: expire is combinational on the last count; the caller registers it.
// Backpressure: none.
// Ports: clock, reset (async active-low), enable (frame open),
//        clear (byte seen this cycle), expire (one-cycle abort request).
module rx_timeout #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_WIDTH       = 17
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam logic [TO_WIDTH-1:0] LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TO_WIDTH-1:0] cnt;

  // A byte on the same cycle always wins over expiry.
  assign expire = enable && !clear && (cnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || !enable || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TO_WIDTH'(1);
    end
  end

endmodule

// File: rtl/coeff_loader.sv
// Framed byte-stream to 36-bit word loader driving the coefficient memory write port.
// Latency: 1 clock from the 5th data byte strobe to the we pulse.
// Backpressure: none; every rxready byte is consumed, stalled frames abort on timeout.
// Ports: clock, reset (async active-low), bus (coeff_loader_if.slave):
//        rxdata/rxready in; addressW/datain/we, busy/done/error out (all registered).
module coeff_loader
  import coeff_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         TO_WIDTH       = 17
) (
  input  logic           clock,
  input  logic           reset,
  coeff_loader_if.slave  bus
);

  localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_WORD - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  addr_t      addr;
  logic [8:0] words_left;     // 9 bits so a count byte of 0 can mean 256
  logic [2:0] byte_idx;
  logic [27:0] word_sr;       // nibble of byte 0 plus bytes 1..3

  addr_t      wr_addr;
  word_t      wr_data;
  logic       we_r;
  logic       busy_r;
  logic       done_r;
  logic       error_r;

  logic       expire;
  logic       last_byte;

  assign last_byte = (byte_idx == LAST_BYTE);

  rx_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_WIDTH       (TO_WIDTH)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .enable (state != IDLE),
    .clear  (bus.rxready),
    .expire (expire)
  );

  always_comb begin
    state_nxt = state;
    if (expire) begin
      state_nxt = IDLE;
    end else if (bus.rxready) begin
      case (state)
        IDLE:    if (bus.rxdata == SYNC_BYTE) state_nxt = ADDR_H;
        ADDR_H:  state_nxt = ADDR_L;
        ADDR_L:  state_nxt = COUNT;
        COUNT:   state_nxt = DATA;
        // A sync value in DATA is just payload; only the word count ends a frame.
        DATA:    if (last_byte && (words_left == 9'd1)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr       <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      word_sr    <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      we_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      we_r    <= 1'b0;
      done_r  <= 1'b0;
      error_r <= expire;
      state   <= state_nxt;
      busy_r  <= (state_nxt != IDLE);

      // Abort drops whatever part of the word was collected.
      if (expire) begin
        byte_idx <= '0;
      end

      if (bus.rxready) begin
        case (state)
          ADDR_H: addr[8]   <= bus.rxdata[0];
          ADDR_L: addr[7:0] <= bus.rxdata;
          COUNT: begin
            words_left <= (bus.rxdata == 8'd0) ? 9'd256 : {1'b0, bus.rxdata};
            byte_idx   <= '0;
          end
          DATA: begin
            if (last_byte) begin
              wr_data    <= {word_sr, bus.rxdata};
              wr_addr    <= addr;
              we_r       <= 1'b1;
              done_r     <= (words_left == 9'd1);
              addr       <= addr + 9'd1;   // wraps 1FF -> 000
              words_left <= words_left - 9'd1;
              byte_idx   <= '0;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              // Byte 0 carries only the top nibble of the 36-bit word.
              word_sr  <= (byte_idx == 3'd0) ? {24'd0, bus.rxdata[3:0]}
                                             : {word_sr[19:0], bus.rxdata};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.addressW = wr_addr;
  assign bus.datain   = wr_data;
  assign bus.we       = we_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.error    = error_r;

endmodule

// File: tb/tb_coeff_loader.sv
// Self-checking bench for coeff_loader: directed frames plus random payloads.
// Latency: n/a.
// Backpressure: n/a.
module tb_coeff_loader;
  import coeff_loader_pkg::*;

  localparam int TO = 50;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  coeff_loader_if bus();

  coeff_loader #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO),
    .TO_WIDTH       (17)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Observations of the write port, sampled on the falling edge.
  logic [44:0] obs_q[$];
  int done_with_we = 0;
  int done_alone   = 0;
  int err_cnt      = 0;
  int we_double    = 0;
  logic prev_we    = 1'b0;

  always @(negedge clock) begin
    if (bus.we) obs_q.push_back({bus.addressW, bus.datain});
    if (bus.done && bus.we) done_with_we++;
    if (bus.done && !bus.we) done_alone++;
    if (bus.error) err_cnt++;
    if (bus.we && prev_we) we_double++;
    prev_we = bus.we;
  end

  logic [7:0]  tx_q[$];
  logic [44:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drives tx_q; idle cycles carry random junk on rxdata.
  task automatic send(input int max_gap);
    foreach (tx_q[i]) begin
      bus.rxdata  = tx_q[i];
      bus.rxready = 1'b1;
      tick(1);
      bus.rxready = 1'b0;
      bus.rxdata  = 8'($urandom);
      if (max_gap > 0) tick($urandom_range(max_gap, 0));
    end
  endtask

  task automatic make_frame(input logic [8:0] start, input int n);
    tx_q.delete();
    tx_q.push_back(8'hA5);
    tx_q.push_back({7'($urandom), start[8]});
    tx_q.push_back(start[7:0]);
    tx_q.push_back((n == 256) ? 8'h00 : 8'(n));
    repeat (n * 5) tx_q.push_back(8'($urandom));
  endtask

  // Reference: decode one whole frame from the byte list.
  task automatic model_frame();
    int start, n;
    logic [35:0] w;
    exp_q.delete();
    start = {tx_q[1][0], tx_q[2]};
    n = (tx_q[3] == 8'd0) ? 256 : int'(tx_q[3]);
    for (int i = 0; i < n; i++) begin
      w = {tx_q[4+5*i][3:0], tx_q[5+5*i], tx_q[6+5*i], tx_q[7+5*i], tx_q[8+5*i]};
      exp_q.push_back({9'((start + i) % 512), w});
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    done_with_we = 0;
    done_alone   = 0;
    err_cnt      = 0;
    we_double    = 0;
  endtask

  task automatic check_frame(input string tag);
    int n;
    tick(4);
    chk({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_wr%0d", tag, i), obs_q[i], exp_q[i]);
    chk({tag, "_done_with_we"}, done_with_we, (exp_q.size() > 0) ? 1 : 0);
    chk({tag, "_done_alone"}, done_alone, 0);
    chk({tag, "_we_double"}, we_double, 0);
    chk({tag, "_error"}, err_cnt, 0);
    chk({tag, "_busy_after"}, bus.busy, 1'b0);
    clear_obs();
  endtask

  initial begin
    bus.rxdata  = 8'h00;
    bus.rxready = 1'b0;

    // Reset values.
    tick(3);
    @(negedge clock);
    chk("rst_we", bus.we, 1'b0);
    chk("rst_addr", bus.addressW, 9'h000);
    chk("rst_data", bus.datain, 36'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_error", bus.error, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick(2);

    // Garbage in IDLE changes nothing.
    tx_q = '{8'h00, 8'hFF, 8'h5A};
    send(1);
    tick(2);
    chk("garbage_busy", bus.busy, 1'b0);
    chk("garbage_writes", obs_q.size(), 0);
    clear_obs();

    // Single-word frame.
    tx_q = '{8'hA5, 8'h01, 8'h05, 8'h01, 8'h0F, 8'h12, 8'h34, 8'h56, 8'h78};
    exp_q = '{{9'h105, 36'hF12345678}};
    send(0);
    check_frame("single");

    // Two-word burst, top nibble of byte 0 ignored.
    tx_q = '{8'hA5, 8'h00, 8'h10, 8'h02, 8'hF1, 8'h23, 8'h45, 8'h67, 8'h89,
             8'h0A, 8'hBC, 8'hDE, 8'hF0, 8'h12};
    exp_q = '{{9'h010, 36'h123456789}, {9'h011, 36'hABCDEF012}};
    send(1);
    check_frame("burst2");

    // Address wrap.
    make_frame(9'h1FF, 2);
    model_frame();
    chk("wrap_model_a1", exp_q[1][44:36], 9'h000);
    send(2);
    check_frame("wrap");

    // Count byte zero means 256 words, back-to-back bytes.
    make_frame(9'h000, 256);
    model_frame();
    send(0);
    check_frame("count0");

    // Random frames; a sync value inside the payload is plain data.
    for (int k = 0; k < 4; k++) begin
      make_frame(9'($urandom), int'($urandom_range(6, 1)));
      tx_q[5] = 8'hA5;
      model_frame();
      send(3);
      check_frame($sformatf("rand%0d", k));
    end

    // Timeout mid-word.
    tx_q = '{8'hA5, 8'h00, 8'h20, 8'h01, 8'h00, 8'h11};
    send(0);
    tick(TO - 10);
    chk("to_early_error", err_cnt, 0);
    chk("to_early_busy", bus.busy, 1'b1);
    tick(20);
    chk("to_error_once", err_cnt, 1);
    chk("to_busy", bus.busy, 1'b0);
    chk("to_writes", obs_q.size(), 0);
    clear_obs();
    make_frame(9'h020, 1);
    model_frame();
    send(0);
    check_frame("after_to");

    // Reset in the middle of DATA.
    tx_q = '{8'hA5, 8'h00, 8'h40, 8'h01, 8'h11, 8'h22};
    send(0);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_we", bus.we, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_addr", bus.addressW, 9'h000);
    chk("midrst_data", bus.datain, 36'h0);
    tick(3);
    reset = 1'b1;
    tick(1);
    clear_obs();
    tx_q = '{8'h33, 8'h44, 8'h55};
    send(0);
    make_frame(9'h077, 1);
    model_frame();
    send(0);
    check_frame("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
